maxnet_controller: RTL and testbench

MAXNET_CONTROLLER -- requirements
Module: maxnet_controller

---
 rtl/maxnet_controller.sv | 153 +++++++++++++++
 tb/tb_maxnet_controller.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/maxnet_controller.sv
// Sequencing controller for a MaxNet winner-take-all datapath: loads the
// initial activations, then repeats PLU update iterations until one winner remains.
module maxnet_controller #(
    parameter int MAX_ITER    = 255,
    parameter int PLU_TIMEOUT = 64,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             abort,
    input  logic             plu_done,
    input  logic             finish,
    output logic             rst_plu,
    output logic             eps_reg_we,
    output logic             we_prim,
    output logic             we_a_reg,
    output logic             mux_sel,
    output logic             start,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] iter_count
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD   = 4'd1,
        S_CLR    = 4'd2,
        S_START  = 4'd3,
        S_WAIT   = 4'd4,
        S_UPDATE = 4'd5,
        S_CHECK  = 4'd6,
        S_DONE   = 4'd7,
        S_FAIL   = 4'd8
    } state_t;

    localparam logic [CNT_W-1:0] ITER_LIM = CNT_W'(MAX_ITER);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(PLU_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] tmo_r;
    logic [CNT_W-1:0] tmo_nxt_s;
    logic [CNT_W-1:0] iter_nxt_s;
    logic [1:0]       err_nxt_s;

    // Output vector {rst_plu, eps_reg_we, we_prim, we_a_reg, mux_sel, start, busy, done, error}
    function automatic logic [8:0] decode(input state_t s);
        logic [8:0] v;
        case (s)
            S_IDLE:   v = 9'b000000000;
            S_LOAD:   v = 9'b011100100;
            S_CLR:    v = 9'b100000100;
            S_START:  v = 9'b000001100;
            S_WAIT:   v = 9'b000000100;
            S_UPDATE: v = 9'b000110100;
            S_CHECK:  v = 9'b000000100;
            S_DONE:   v = 9'b000000110;
            S_FAIL:   v = 9'b000000101;
            default:  v = 9'b000000000;
        endcase
        return v;
    endfunction

    // Next-state, counter and error-code logic; abort outranks every transition
    always_comb begin
        state_nxt_s = state_r;
        tmo_nxt_s   = tmo_r;
        iter_nxt_s  = iter_count;
        err_nxt_s   = err_code;
        if ((state_r != S_IDLE) && abort) begin
            state_nxt_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    // err_code and iter_count are cleared on the accepting edge so LOAD starts clean
                    if (go && !abort) begin
                        state_nxt_s = S_LOAD;
                        iter_nxt_s  = CNT_ZERO;
                        err_nxt_s   = 2'b00;
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end
                S_LOAD:  state_nxt_s = S_CLR;
                S_CLR:   state_nxt_s = S_START;
                S_START: begin
                    tmo_nxt_s   = CNT_ZERO;
                    state_nxt_s = S_WAIT;
                end
                S_WAIT: begin
                    if (tmo_r != CNT_MAX) begin
                        tmo_nxt_s = tmo_r + CNT_ONE;
                    end else begin
                        tmo_nxt_s = tmo_r;
                    end
                    if (plu_done) begin
                        state_nxt_s = S_UPDATE;
                    end else if (tmo_r == TMO_LAST) begin
                        err_nxt_s   = 2'b10;
                        state_nxt_s = S_FAIL;
                    end else begin
                        state_nxt_s = S_WAIT;
                    end
                end
                S_UPDATE: begin
                    if (iter_count != CNT_MAX) begin
                        iter_nxt_s = iter_count + CNT_ONE;
                    end else begin
                        iter_nxt_s = iter_count;
                    end
                    state_nxt_s = S_CHECK;
                end
                S_CHECK: begin
                    if (finish) begin
                        state_nxt_s = S_DONE;
                    end else if (iter_count == ITER_LIM) begin
                        err_nxt_s   = 2'b01;
                        state_nxt_s = S_FAIL;
                    end else begin
                        state_nxt_s = S_CLR;
                    end
                end
                S_DONE:  state_nxt_s = S_IDLE;
                S_FAIL:  state_nxt_s = S_IDLE;
                default: state_nxt_s = S_IDLE;
            endcase
        end
    end

    // State and counters, with the strobes registered from the next state so they align with it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            tmo_r      <= CNT_ZERO;
            iter_count <= CNT_ZERO;
            err_code   <= 2'b00;
            {rst_plu, eps_reg_we, we_prim, we_a_reg, mux_sel, start, busy, done, error} <= 9'b000000000;
        end else begin
            state_r    <= state_nxt_s;
            tmo_r      <= tmo_nxt_s;
            iter_count <= iter_nxt_s;
            err_code   <= err_nxt_s;
            {rst_plu, eps_reg_we, we_prim, we_a_reg, mux_sel, start, busy, done, error} <= decode(state_nxt_s);
        end
    end

endmodule

// File: tb/tb_maxnet_controller.sv
// Bench for maxnet_controller: a phase-level reference model checked every cycle,
// directed scenarios with hand-computed latencies, then randomized traffic.
module tb_maxnet_controller;
    localparam int MAX_ITER    = 4;
    localparam int PLU_TIMEOUT = 8;
    localparam int CNT_W       = 8;
    localparam int ITER_SAT    = (1 << CNT_W) - 1;

    localparam int PH_IDLE = 0, PH_LOAD = 1, PH_CLR = 2, PH_START = 3, PH_WAIT = 4,
                   PH_UPDATE = 5, PH_CHECK = 6, PH_DONE = 7, PH_FAIL = 8;

    logic clk = 1'b0;
    logic rst = 1'b1, go = 1'b0, abort = 1'b0, plu_done = 1'b0, finish = 1'b0;
    logic rst_plu, eps_reg_we, we_prim, we_a_reg, mux_sel, start, busy, done, error;
    logic [1:0] err_code;
    logic [CNT_W-1:0] iter_count;

    int n_cmp = 0;
    int n_bad = 0;

    maxnet_controller #(.MAX_ITER(MAX_ITER), .PLU_TIMEOUT(PLU_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .go(go), .abort(abort), .plu_done(plu_done), .finish(finish),
        .rst_plu(rst_plu), .eps_reg_we(eps_reg_we), .we_prim(we_prim), .we_a_reg(we_a_reg),
        .mux_sel(mux_sel), .start(start), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    // Reference model: which phase of a run we are in, waited cycles, iterations done
    int m_ph = PH_IDLE;
    int m_tmo = 0;
    int m_iter = 0;
    int m_err = 0;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_ph <= PH_IDLE; m_tmo <= 0; m_iter <= 0; m_err <= 0; m_valid <= 1'b1;
        end else if (m_ph != PH_IDLE && abort) begin
            m_ph <= PH_IDLE;
        end else begin
            case (m_ph)
                PH_IDLE:  if (go && !abort) begin m_ph <= PH_LOAD; m_iter <= 0; m_err <= 0; end
                PH_LOAD:  m_ph <= PH_CLR;
                PH_CLR:   m_ph <= PH_START;
                PH_START: begin m_ph <= PH_WAIT; m_tmo <= 0; end
                PH_WAIT: begin
                    m_tmo <= m_tmo + 1;
                    if (plu_done) m_ph <= PH_UPDATE;
                    else if (m_tmo == PLU_TIMEOUT - 1) begin m_ph <= PH_FAIL; m_err <= 2; end
                end
                PH_UPDATE: begin
                    m_ph <= PH_CHECK;
                    if (m_iter < ITER_SAT) m_iter <= m_iter + 1;
                end
                PH_CHECK: begin
                    if (finish) m_ph <= PH_DONE;
                    else if (m_iter == MAX_ITER) begin m_ph <= PH_FAIL; m_err <= 1; end
                    else m_ph <= PH_CLR;
                end
                default: m_ph <= PH_IDLE;
            endcase
        end
    end

    // Strobes each phase raises: {rst_plu, eps_reg_we, we_prim, we_a_reg, mux_sel, start, busy, done, error}
    function automatic logic [8:0] expect_outs(input int ph);
        logic [8:0] v;
        v = 9'b0;
        if (ph != PH_IDLE) v[2] = 1'b1;
        if (ph == PH_LOAD) begin v[7] = 1'b1; v[6] = 1'b1; v[5] = 1'b1; end
        if (ph == PH_CLR) v[8] = 1'b1;
        if (ph == PH_START) v[3] = 1'b1;
        if (ph == PH_UPDATE) begin v[5] = 1'b1; v[4] = 1'b1; end
        if (ph == PH_DONE) v[1] = 1'b1;
        if (ph == PH_FAIL) v[0] = 1'b1;
        return v;
    endfunction

    task automatic model_cmp();
        logic [8:0] act;
        logic [8:0] exp_v;
        act = {rst_plu, eps_reg_we, we_prim, we_a_reg, mux_sel, start, busy, done, error};
        exp_v = expect_outs(m_ph);
        n_cmp++;
        if (act !== exp_v || int'(err_code) != m_err || int'(iter_count) != m_iter || $isunknown(err_code)) begin
            n_bad++;
            $display("FAIL model t=%0t outs=%b want=%b err_code=%0d want=%0d iter=%0d want=%0d",
                     $time, act, exp_v, err_code, m_err, iter_count, m_iter);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (m_valid) model_cmp();
    endtask

    task automatic chk(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp_v);
        end
    endtask

    int n;
    bit seen;

    initial begin
        tick(); tick();
        chk("reset_outs", int'({rst_plu, eps_reg_we, we_prim, we_a_reg, mux_sel, start, busy, done, error}), 0);
        chk("reset_iter", int'(iter_count), 0);
        rst = 1'b0;
        tick();

        // Converge in the third CHECK: done after 16 edges, i.e. in cycle 17
        go = 1'b1; plu_done = 1'b1; tick(); go = 1'b0; n = 0;
        while (n < 40 && !done) begin finish = (n >= 12); tick(); n++; end
        finish = 1'b0;
        chk("conv_latency", n, 16);
        chk("conv_iter", int'(iter_count), 3);
        chk("conv_err", int'(err_code), 0);
        tick();
        chk("conv_idle_busy", int'(busy), 0);

        // Iteration limit: error after the 4th CHECK
        go = 1'b1; tick(); go = 1'b0; n = 0; seen = 1'b0;
        while (n < 60 && !error) begin tick(); n++; if (done) seen = 1'b1; end
        chk("iterlim_latency", n, 21);
        chk("iterlim_err", int'(err_code), 1);
        chk("iterlim_iter", int'(iter_count), 4);
        chk("iterlim_no_done", int'(seen), 0);
        tick();

        // plu_done on the last allowed WAIT cycle wins over the timeout
        plu_done = 1'b0; go = 1'b1; tick(); go = 1'b0; n = 0;
        while (n < 11) begin plu_done = (n >= 10); tick(); n++; end
        plu_done = 1'b0;
        chk("race_update", int'(we_a_reg & mux_sel), 1);
        chk("race_no_error", int'(error), 0);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("race_abort_idle", int'(busy), 0);

        // PLU timeout after 8 WAIT cycles
        go = 1'b1; tick(); go = 1'b0; n = 0;
        while (n < 40 && !error) begin tick(); n++; end
        chk("timeout_latency", n, 11);
        chk("timeout_err", int'(err_code), 2);
        chk("timeout_iter", int'(iter_count), 0);
        tick();

        // Abort in the 2nd WAIT with go held; the held go restarts with LOAD
        go = 1'b1; tick(); n = 0;
        while (n < 4) begin tick(); n++; end
        abort = 1'b1; tick();
        chk("abort_busy", int'(busy), 0);
        chk("abort_no_pulse", int'(done | error), 0);
        abort = 1'b0; tick();
        chk("abort_reload", int'(we_prim & eps_reg_we), 1);
        go = 1'b0; abort = 1'b1; tick(); abort = 1'b0; tick();

        // Reset during the second UPDATE
        plu_done = 1'b1; go = 1'b1; tick(); go = 1'b0; n = 0;
        while (n < 9) begin tick(); n++; end
        chk("rst_pre_iter", int'(iter_count), 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_outs", int'({rst_plu, eps_reg_we, we_prim, we_a_reg, mux_sel, start, busy, done, error}), 0);
        chk("rst_iter", int'(iter_count), 0);

        // go while busy must not relaunch LOAD
        plu_done = 1'b0; go = 1'b1; tick(); go = 1'b0; tick(); tick(); tick();
        go = 1'b1; tick(); go = 1'b0;
        chk("busy_go_ignored", int'(we_prim), 0);
        chk("busy_go_still_busy", int'(busy), 1);
        abort = 1'b1; tick(); abort = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            go       = ($urandom_range(0, 3) == 0);
            abort    = ($urandom_range(0, 29) == 0);
            plu_done = ($urandom_range(0, 2) == 0);
            finish   = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
